// File: rtl/blink_sequencer.sv
// LED pattern sequencer: accepts a mode/repetition command, steps a 16-bit
// LED pattern once every TICK_DIV clocks and reports completion with done.
module blink_sequencer #(
    parameter int unsigned TICK_DIV = 32'd10000000
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_mode,
    input  logic [7:0]  cmd_reps,
    input  logic        stop,
    output logic [15:0] led_out,
    output logic        busy,
    output logic        done,
    output logic        tick
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] DIV_LAST = 32'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  reps_q, reps_d;
    logic [31:0] div_q, div_d;
    logic [3:0]  step_q, step_d;
    logic [7:0]  rep_q, rep_d;
    logic        dir_q, dir_d;   // bounce direction: 0 = towards bit15
    logic [15:0] led_q, led_d;
    logic        tick_w;

    // A coincident stop suppresses the step that would otherwise happen.
    assign tick_w = (state_q == RUN) && (div_q == DIV_LAST) && !stop;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statements can leave one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        reps_d  = reps_q;
        div_d   = div_q;
        step_d  = step_q;
        rep_d   = rep_q;
        dir_d   = dir_q;
        led_d   = led_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = RUN;
                    mode_d  = cmd_mode;
                    reps_d  = cmd_reps;
                    div_d   = '0;
                    step_d  = '0;
                    rep_d   = '0;
                    dir_d   = 1'b0;
                    unique case (cmd_mode)
                        2'd0:    led_d = 16'hFFFF;
                        2'd1:    led_d = 16'h0001;
                        2'd2:    led_d = 16'h0001;
                        default: led_d = 16'h0000;
                    endcase
                end
            end

            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    led_d   = '0;
                end else begin
                    div_d = (div_q == DIV_LAST) ? '0 : div_q + 32'd1;
                    if (tick_w) begin
                        unique case (mode_q)
                            2'd0: led_d = ~led_q;
                            2'd1: led_d = {led_q[14:0], led_q[15]};
                            2'd2: begin
                                if (!dir_q) begin
                                    led_d = led_q << 1;
                                    if (led_q[14]) dir_d = 1'b1;
                                end else begin
                                    led_d = led_q >> 1;
                                    if (led_q[1]) dir_d = 1'b0;
                                end
                            end
                            default: led_d = led_q + 16'd1;
                        endcase
                        step_d = step_q + 4'd1;
                        if (step_q == 4'hF) begin
                            rep_d = rep_q + 8'd1;
                            // reps == 0 runs forever; the repetition count just wraps.
                            if (reps_q != 8'd0 && rep_q == reps_q - 8'd1) begin
                                state_d = DONE;
                            end
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                led_d   = '0;
            end

            default: begin
                state_d = IDLE;
                led_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= IDLE;
            mode_q  <= '0;
            reps_q  <= '0;
            div_q   <= '0;
            step_q  <= '0;
            rep_q   <= '0;
            dir_q   <= 1'b0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            reps_q  <= reps_d;
            div_q   <= div_d;
            step_q  <= step_d;
            rep_q   <= rep_d;
            dir_q   <= dir_d;
            led_q   <= led_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign led_out   = led_q;
    assign tick      = tick_w && !reset_in;

endmodule

// File: doc/blink_sequencer.md
BLINK_SEQUENCER -- requirements
Module: blink_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10000000, clock cycles per pattern step (100 MHz -> 10 Hz); legal range 2..2^32-1.
REQ-002 SHALL have port clock_in, input, 1, system clock; all logic on posedge clock_in.
REQ-003 SHALL have port reset_in, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port cmd_valid, input, 1, command request.
REQ-005 SHALL have port cmd_ready, output, 1, high only in IDLE.
REQ-006 SHALL have port cmd_mode, input, 2, pattern select: 0 toggle-all, 1 walk-left, 2 bounce, 3 binary count.
REQ-007 SHALL have port cmd_reps, input, 8, repetitions to run; 0 = run until stopped.
REQ-008 SHALL have port stop, input, 1, abort request.
REQ-009 SHALL have port led_out, output, 16, LED pattern.
REQ-010 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port tick, output, 1, one-cycle pulse on each pattern step.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; transitions: IDLE->RUN on cmd_valid&cmd_ready; RUN->DONE on final step; RUN->IDLE on stop; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL accept a command only when cmd_valid and cmd_ready are both high in the same cycle; mode and reps latched at acceptance; cmd_valid outside IDLE ignored, no queuing.
REQ-015 SHALL load led_out on the cycle after acceptance: mode0 16'hFFFF, mode1 16'h0001, mode2 16'h0001, mode3 16'h0000.
REQ-016 SHALL clear the 32-bit divider at acceptance; in RUN it counts 0..TICK_DIV-1, and tick pulses for one cycle when it equals TICK_DIV-1, when it wraps to 0; the first tick occurs TICK_DIV cycles after acceptance.
REQ-017 SHALL advance led_out only on tick: mode0 invert all bits; mode1 rotate left one (bit15->bit0); mode2 shift one position in current direction, reversing direction on reaching bit15 or bit0 (0x0001->0x0002...0x8000->0x4000...); mode3 increment modulo 2^16.
REQ-018 SHALL define one repetition as 16 ticks, tracked by a 4-bit step counter and an 8-bit repetition counter, both cleared at acceptance.
REQ-019 SHALL, when cmd_reps != 0, enter DONE on the tick completing repetition cmd_reps (tick number 16*cmd_reps), with led_out updated by that tick and held through DONE.
REQ-020 SHALL, when cmd_reps == 0, remain in RUN indefinitely, with repetition counter wrap having no effect.
REQ-021 SHALL assert done for exactly the one DONE cycle; done never asserts on an abort.
REQ-022 SHALL, on stop in RUN, go to IDLE next cycle with led_out = 0, no done, and no tick that cycle; stop wins over a coincident final tick.
REQ-023 SHALL ignore stop in IDLE and DONE; a command presented with stop in IDLE is accepted.
REQ-024 SHALL set led_out = 0 on every entry to IDLE.
REQ-025 SHALL keep tick low outside RUN.

Reset
REQ-026 SHALL, when reset_in is high at a clock edge, force IDLE, led_out=0, cmd_ready=1 after reset, busy=0, done=0, tick=0, divider/step/repetition counters=0, and bounce direction=left, overriding any concurrent command or stop.
REQ-027 SHALL abort a running sequence on reset mid-operation, with no done pulse.

Verification (TICK_DIV=4)
REQ-028 SHALL verify: reset, then mode1 reps=1 accepted -> led_out 0x0001 next cycle, tick every 4 cycles, 0x0002,0x0004..., 16th tick yields 0x0001, done=1 one cycle, then IDLE, led_out=0.
REQ-029 SHALL verify: mode2 reps=2 -> 32 ticks run, led_out peaks 0x8000 at tick 15, reads 0x4000 at tick 16, and done follows tick 32.
REQ-030 SHALL verify: mode3 reps=0, stop after 100 ticks -> led_out=0x0064 before stop, IDLE next cycle, led_out=0, no done.
REQ-031 SHALL verify: cmd_valid held high during RUN -> cmd_ready=0, command not accepted; new command accepted the cycle after return to IDLE.
REQ-032 SHALL verify: stop coincident with final tick of mode0 reps=1 -> IDLE, no done; reset asserted mid-RUN -> all outputs at reset values next cycle.
REQ-033 SHALL verify: mode0 reps=1 -> led_out alternates 0xFFFF/0x0000 per tick and ends 0xFFFF after 16 ticks.
